// File: rtl/arm_target_arbiter.sv
// arm_target_arbiter
// Fixed-priority arbiter over NUM_SRC coordinate sources. It registers the
// winning (x,y) request, slews the committed target toward it one unit per
// tick per axis, and owns servo-enable timing with a post-move hold window.
// Optional build macro: ARM_TARGET_CLAMP_EN saturates requests to
// X_MAX/Y_MAX and pulses range_err; without it range_err is tied low.
module arm_target_arbiter #(
    parameter int                   NUM_SRC       = 2,
    parameter int                   COORD_W       = 8,
    parameter int                   SLEW_DIV      = 1000000,
    parameter int                   HOLD_CYCLES   = 140000000,
    parameter int                   HOME_X        = 2,
    parameter int                   HOME_Y        = 2,
    parameter logic [NUM_SRC-1:0]   FORCE_EN_MASK = 2'b10,
    parameter int                   X_MAX         = 255,
    parameter int                   Y_MAX         = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_SRC-1:0]                  src_valid,
    input  logic [NUM_SRC*COORD_W-1:0]          src_x,
    input  logic [NUM_SRC*COORD_W-1:0]          src_y,
    output logic [COORD_W-1:0]                  req_x,
    output logic [COORD_W-1:0]                  req_y,
    output logic [COORD_W-1:0]                  tgt_x,
    output logic [COORD_W-1:0]                  tgt_y,
    output logic [$clog2(NUM_SRC):0]            grant,
    output logic                                servo_en,
    output logic                                moving,
    output logic                                range_err
);

    localparam int GRANT_W = $clog2(NUM_SRC) + 1;
    localparam int TICK_W  = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [GRANT_W-1:0] GRANT_NONE = '1;
    localparam logic [COORD_W-1:0] HOME_X_C   = COORD_W'(HOME_X);
    localparam logic [COORD_W-1:0] HOME_Y_C   = COORD_W'(HOME_Y);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SLEW_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

    // Elaboration-time guards on parameters that would break the counters
    // or the clamp limits.
    generate
        if (SLEW_DIV < 1) begin : g_bad_slew
            $error("arm_target_arbiter: SLEW_DIV must be >= 1");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("arm_target_arbiter: HOLD_CYCLES must be >= 1");
        end
        if (X_MAX < 0 || Y_MAX < 0) begin : g_bad_max
            $error("arm_target_arbiter: X_MAX/Y_MAX must be non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [COORD_W-1:0]     r_req_x;
    logic [COORD_W-1:0]     r_req_y;
    logic [COORD_W-1:0]     r_tgt_x;
    logic [COORD_W-1:0]     r_tgt_y;
    logic [GRANT_W-1:0]     r_grant;
    logic                   r_servo_en;
    logic                   r_moving;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]     w_src_x [NUM_SRC];
    logic [COORD_W-1:0]     w_src_y [NUM_SRC];
    logic [COORD_W-1:0]     w_arb_x;
    logic [COORD_W-1:0]     w_arb_y;
    logic [GRANT_W-1:0]     w_grant_next;
    logic [COORD_W-1:0]     w_req_x_next;
    logic [COORD_W-1:0]     w_req_y_next;
    logic                   w_tick;
    logic [COORD_W-1:0]     w_tgt_x_next;
    logic [COORD_W-1:0]     w_tgt_y_next;
    logic                   w_settled;
    state_t                 w_state_next;
    logic [HOLD_W-1:0]      w_hold_next;
    logic                   w_force;
    logic                   w_servo_en_next;
    logic                   w_moving_next;

    // Unpack the flat source buses into per-source coordinates.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_x[gi] = src_x[gi*COORD_W +: COORD_W];
            assign w_src_y[gi] = src_y[gi*COORD_W +: COORD_W];
        end
    endgenerate

    // Fixed priority: scanning from the top index down lets the lowest
    // valid index overwrite everything above it, so index 0 wins.
    always_comb begin
        w_arb_x      = HOME_X_C;
        w_arb_y      = HOME_Y_C;
        w_grant_next = GRANT_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                w_arb_x      = w_src_x[i];
                w_arb_y      = w_src_y[i];
                w_grant_next = GRANT_W'(i);
            end
        end
    end

`ifdef ARM_TARGET_CLAMP_EN
    localparam logic [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);

    logic w_clamp;
    logic r_clamp_last;
    logic r_range_err;

    // Saturate the arbitrated request to the reachable workspace.
    always_comb begin
        w_req_x_next = w_arb_x;
        w_req_y_next = w_arb_y;
        w_clamp      = 1'b0;
        if (w_arb_x > X_MAX_C) begin
            w_req_x_next = X_MAX_C;
            w_clamp      = 1'b1;
        end
        if (w_arb_y > Y_MAX_C) begin
            w_req_y_next = Y_MAX_C;
            w_clamp      = 1'b1;
        end
    end

    // range_err marks the start of a saturation episode: one cycle high on
    // the edge the clamped request is first registered, not every cycle a
    // held out-of-range request stays present.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clamp_last <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_clamp_last <= w_clamp;
            r_range_err  <= w_clamp & ~r_clamp_last;
        end
    end

    assign range_err = r_range_err;
`else
    assign w_req_x_next = w_arb_x;
    assign w_req_y_next = w_arb_y;
    assign range_err    = 1'b0;
`endif

    // Slew tick: free-running divider, pulses on the last count.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Tick divider, runs in every FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // One-unit step per axis toward the registered request. Comparing
    // before stepping means the target can never cross or wrap past req.
    always_comb begin
        w_tgt_x_next = r_tgt_x;
        w_tgt_y_next = r_tgt_y;
        if (w_tick) begin
            if (r_tgt_x < r_req_x) begin
                w_tgt_x_next = r_tgt_x + 1'b1;
            end else if (r_tgt_x > r_req_x) begin
                w_tgt_x_next = r_tgt_x - 1'b1;
            end
            if (r_tgt_y < r_req_y) begin
                w_tgt_y_next = r_tgt_y + 1'b1;
            end else if (r_tgt_y > r_req_y) begin
                w_tgt_y_next = r_tgt_y - 1'b1;
            end
        end
    end

    // The FSM looks at next-cycle req/tgt so the registered state always
    // agrees with the registered coordinates it is presented alongside.
    assign w_settled = (w_tgt_x_next == w_req_x_next) &&
                       (w_tgt_y_next == w_req_y_next);

    // A granted source flagged in FORCE_EN_MASK keeps the servos powered.
    always_comb begin
        w_force = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((w_grant_next == GRANT_W'(i)) && FORCE_EN_MASK[i]) begin
                w_force = 1'b1;
            end
        end
    end

    // Next-state and registered-output decode for the servo-enable FSM.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                w_hold_next = '0;
                if (!w_settled) begin
                    w_state_next = ST_MOVE;
                end
            end
            ST_MOVE: begin
                w_hold_next = '0;
                if (w_settled) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!w_settled) begin
                    w_state_next = ST_MOVE;
                    w_hold_next  = '0;
                end else if (r_hold_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_hold_next = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hold_next  = '0;
            end
        endcase
        w_servo_en_next = (w_state_next != ST_IDLE) | w_force;
        w_moving_next   = (w_state_next == ST_MOVE);
    end

    // All datapath and FSM state; reset snaps the target home with no slew.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_req_x    <= HOME_X_C;
            r_req_y    <= HOME_Y_C;
            r_tgt_x    <= HOME_X_C;
            r_tgt_y    <= HOME_Y_C;
            r_grant    <= GRANT_NONE;
            r_servo_en <= 1'b0;
            r_moving   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_req_x    <= w_req_x_next;
            r_req_y    <= w_req_y_next;
            r_tgt_x    <= w_tgt_x_next;
            r_tgt_y    <= w_tgt_y_next;
            r_grant    <= w_grant_next;
            r_servo_en <= w_servo_en_next;
            r_moving   <= w_moving_next;
        end
    end

    assign req_x    = r_req_x;
    assign req_y    = r_req_y;
    assign tgt_x    = r_tgt_x;
    assign tgt_y    = r_tgt_y;
    assign grant    = r_grant;
    assign servo_en = r_servo_en;
    assign moving   = r_moving;

endmodule
